// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the
// integer/float converters.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int FRAC_W   = 23;
  localparam int UINT_W   = 24;
  localparam int EXP_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/uint_to_float.sv
// 24-bit unsigned to IEEE-754 single converter;
// normalises one bit per clock.
module uint_to_float
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UINT_W-1:0] uint_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       float_out
);

  // Unshifted value already sits at 2^23 scale.
  localparam logic [EXP_W-1:0] EXP_INIT =
    EXP_W'(EXP_BIAS + FRAC_W);

  state_e            state_q, state_d;
  logic [UINT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [31:0]       float_q, float_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      float_q <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      float_q <= float_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    float_d = float_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (uint_in == '0) begin
            float_d = '0;
            state_d = DONE;
          end else begin
            mant_d  = uint_in;
            exp_d   = EXP_INIT;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mant_q[UINT_W-1]) begin
          float_d = {1'b0, exp_q,
                     mant_q[FRAC_W-1:0]};
          state_d = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign float_out = float_q;

endmodule

// File: tb/tb_uint_to_float.sv
// Directed + random checks for uint_to_float.
// Inputs driven 1ns after rising edges.
module tb_uint_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] uint_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_out;

  int n_vec = 0;
  int n_err = 0;

  uint_to_float dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uint_in   (uint_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .float_out (float_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f2u(
    input logic [31:0] f);
    int sh;
    logic [23:0] m;
    if (f == 32'h0) return 32'h0;
    sh = 150 - int'(f[30:23]);
    m  = {1'b1, f[22:0]};
    if (sh < 0 || sh > 23) return 32'hDEAD_BEEF;
    return 32'(m >> sh);
  endfunction

  // Accept-edge excluded; zero lands in DONE
  // on the accepting edge itself.
  task automatic run(input logic [23:0] v,
                     input logic [31:0] ef,
                     input int el,
                     input int stall);
    int lat;
    logic [31:0] held;
    chk("in_ready_idle", 32'(in_ready), 32'h1);
    uint_in   = v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("float_out", float_out, ef);
    chk("f2u", f2u(float_out), 32'(v));
    held = float_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_hold", float_out, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", 32'(out_valid), 32'h0);
    chk("post_ready", 32'(in_ready), 32'h1);
  endtask

  task automatic model(input logic [23:0] v,
                       output logic [31:0] f,
                       output int lat);
    int k;
    logic [23:0] m;
    if (v == 24'h0) begin
      f = 32'h0;
      lat = 0;
      return;
    end
    k = 0;
    for (int i = 0; i < 24; i++)
      if (v[i]) k = i;
    m   = v << (23 - k);
    f   = {1'b0, 8'(127 + k), m[22:0]};
    lat = 24 - k;
  endtask

  initial begin
    logic [31:0] ef;
    logic [31:0] held;
    logic [23:0] v;
    int el;
    int lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    uint_in   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_float", float_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(24'd42,      32'h4228_0000, 19, 0);
    run(24'd8,       32'h4100_0000, 21, 0);
    run(24'd1234567, 32'h4996_B438,  4, 0);
    run(24'd0,       32'h0000_0000,  0, 0);
    run(24'hFFFFFF,  32'h4B7F_FFFF,  1, 0);
    run(24'd1,       32'h3F80_0000, 24, 0);

    // back-pressure with a pending input held
    uint_in   = 24'd42;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    uint_in = 24'd8;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd19);
    chk("bp_float", float_out, 32'h4228_0000);
    held = float_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", float_out, held);
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", 32'(in_ready), 32'h1);
    chk("bp_novalid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", 32'(in_ready), 32'h0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_latency", 32'(lat), 32'd21);
    chk("bp2_float", float_out, 32'h4100_0000);
    @(posedge clk); #1;

    // asynchronous abort mid-normalisation
    uint_in  = 24'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'h0);
    chk("abort_ready", 32'(in_ready), 32'h1);
    chk("abort_float", float_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(24'd42, 32'h4228_0000, 19, 0);

    for (int n = 0; n < 40; n++) begin
      v = 24'($urandom);
      if (n % 4 == 0) v = v >> $urandom_range(23, 0);
      model(v, ef, el);
      run(v, ef, el, int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
